// File: rtl/mux4_seq_pkg.sv
// rtl/mux4_seq_pkg.sv - shared lane types, constants and round-robin pick for mux4_rr_sequencer
package mux4_seq_pkg;

  localparam int LANE_CNT    = 4;
  localparam bit MUX_INVERTS = 1'b1;

  typedef logic [1:0] lane_idx_t;

  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } pick_t;

  // Walk offsets high to low so the lowest offset from ptr is written last and wins.
  function automatic pick_t rr_pick(input logic [LANE_CNT-1:0] req, input lane_idx_t ptr);
    pick_t     p;
    lane_idx_t c;
    p = '0;
    for (int k = LANE_CNT - 1; k >= 0; k--) begin
      c = ptr + lane_idx_t'(k);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_rr_sequencer_arb.sv
// rtl/mux4_rr_sequencer_arb.sv - rr_arb4: combinational round-robin picker owning its pointer
module rr_arb4
  import mux4_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [LANE_CNT-1:0] req,
  input  logic                en,
  output logic [LANE_CNT-1:0] grant,
  output lane_idx_t           idx,
  output logic                found
);

  lane_idx_t ptr;
  pick_t     pick;

  always_comb begin
    pick  = rr_pick(req, ptr);
    found = pick.found;
    idx   = pick.idx;
    grant = '0;
    if (en && pick.found) grant[pick.idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= idx + lane_idx_t'(1);
    end
  end

endmodule

// File: rtl/mux4_rr_sequencer.sv
// rtl/mux4_rr_sequencer.sv - round-robin issue/capture harness around a 4:1 inverting mux
// Optional compare/err feature: define MUX4_RR_SEQUENCER_CMP_EN.
module mux4_rr_sequencer
  import mux4_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NLANE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANE_CNT-1:0]       req_valid,
  input  logic [LANE_CNT*WIDTH-1:0] req_data,
  output logic [LANE_CNT-1:0]       req_ready,
  output logic [WIDTH-1:0]          A0,
  output logic [WIDTH-1:0]          A1,
  output logic [WIDTH-1:0]          A2,
  output logic [WIDTH-1:0]          A3,
  output logic                      SL0,
  output logic                      SL1,
  input  logic [WIDTH-1:0]          Z,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [1:0]                out_lane,
  input  logic                      out_ready
`ifdef MUX4_RR_SEQUENCER_CMP_EN
  ,
  output logic                      err
`endif
);

  if (NLANE != LANE_CNT) begin : g_bad_nlane
    $error("mux4_rr_sequencer: NLANE must be 4");
  end

  logic             slot_free;
  logic             issued;
  logic             g_found;
  lane_idx_t        g_idx;
  lane_idx_t        sel;
  logic [WIDTH-1:0] a_q [LANE_CNT];
  logic [WIDTH-1:0] z_true;
  logic [WIDTH-1:0] g_data;

  // Issue and capture advance together; a stalled output freezes both stages.
  assign slot_free = (!out_valid || out_ready) && !rst;
  assign z_true    = MUX_INVERTS ? ~Z : Z;
  assign g_data    = req_data[int'(g_idx)*WIDTH +: WIDTH];

  rr_arb4 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (slot_free),
    .grant (req_ready),
    .idx   (g_idx),
    .found (g_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      issued    <= 1'b0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= '0;
      for (int i = 0; i < LANE_CNT; i++) a_q[i] <= '0;
    end else if (slot_free) begin
      issued <= g_found;
      if (g_found) begin
        sel        <= g_idx;
        a_q[g_idx] <= g_data;
      end
      out_valid <= issued;
      if (issued) begin
        out_data <= z_true;
        out_lane <= sel;
      end
    end
  end

  assign A0  = a_q[0];
  assign A1  = a_q[1];
  assign A2  = a_q[2];
  assign A3  = a_q[3];
  assign SL0 = sel[0];
  assign SL1 = sel[1];

`ifdef MUX4_RR_SEQUENCER_CMP_EN
  logic [WIDTH-1:0] shadow;
  logic             err_q;
  logic             err_pulse;

  // Case-inequality so X/Z from a faulty cell counts as a mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      err_q     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (slot_free) begin
        if (g_found) shadow <= g_data;
        if (issued && (z_true !== shadow)) begin
          err_pulse <= 1'b1;
          err_q     <= 1'b1;
        end
      end
    end
  end

  assign err = err_q | err_pulse;
`endif

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// tb/tb_mux4_rr_sequencer.sv - table-driven and scoreboard bench for mux4_rr_sequencer
module tb_mux4_rr_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_ready;
  logic [W-1:0]   A0, A1, A2, A3;
  logic           SL0, SL1;
  logic [W-1:0]   Z;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_lane;
  logic           out_ready;
  logic           stuck = 1'b0;
`ifdef MUX4_RR_SEQUENCER_CMP_EN
  logic           err;
`endif

  always #5 clk = ~clk;

  mux4_rr_sequencer #(.WIDTH(W), .NLANE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .A0        (A0),
    .A1        (A1),
    .A2        (A2),
    .A3        (A3),
    .SL0       (SL0),
    .SL1       (SL1),
    .Z         (Z),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_ready (out_ready)
`ifdef MUX4_RR_SEQUENCER_CMP_EN
    ,
    .err       (err)
`endif
  );

  // Inverting mux cell model, with an optional bit0 stuck-at-1 fault.
  always_comb begin
    case ({SL1, SL0})
      2'd0:    Z = ~A0;
      2'd1:    Z = ~A1;
      2'd2:    Z = ~A2;
      default: Z = ~A3;
    endcase
    if (stuck) Z[0] = 1'b1;
  end

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       ord;
    logic [3:0] rr;
    logic [1:0] sel;
    logic       ov;
    logic       chk0;
  } vec_t;

  typedef struct {
    logic [1:0]   lane;
    logic [W-1:0] data;
  } exp_t;

  vec_t vt [34];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    exp_t e;
    rst       = v.rst;
    req_valid = v.rv;
    out_ready = v.ord;
    req_data  = 16'($urandom);
    @(negedge clk);
    chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.rr));
    chk($sformatf("v%0d sel", n), 32'({SL1, SL0}), 32'(v.sel));
    chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(v.ov));
`ifdef MUX4_RR_SEQUENCER_CMP_EN
    chk($sformatf("v%0d err", n), 32'(err), 32'd0);
`endif
    if (v.chk0) chk($sformatf("v%0d cleared", n), {A3, A2, A1, A0, out_data, 2'b00, out_lane},
                    32'd0);
    if (v.ov && v.ord) begin
      if (sb.size() == 0) begin
        chk($sformatf("v%0d unexpected output", n), 32'(out_lane), 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d out_lane", n), 32'(out_lane), 32'(e.lane));
        chk($sformatf("v%0d out_data", n), 32'(out_data), 32'(e.data));
      end
    end
    if (v.rst) begin
      sb.delete();
    end else if (v.rr != 4'b0000) begin
      e.lane = onehot_idx(v.rr);
      e.data = req_data[int'(e.lane)*W +: W];
      sb.push_back(e);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        rst  rv       ord  rr       sel ov chk0
    vt[0]  = '{0, 4'b0100, 1, 4'b0100, 0, 0, 0};
    vt[1]  = '{0, 4'b0000, 1, 4'b0000, 2, 0, 0};
    vt[2]  = '{0, 4'b0000, 1, 4'b0000, 2, 1, 0};
    vt[3]  = '{0, 4'b0000, 1, 4'b0000, 2, 0, 0};
    vt[4]  = '{1, 4'b0000, 1, 4'b0000, 2, 0, 0};
    vt[5]  = '{0, 4'b1111, 1, 4'b0001, 0, 0, 1};
    vt[6]  = '{0, 4'b1111, 1, 4'b0010, 0, 0, 0};
    vt[7]  = '{0, 4'b1111, 1, 4'b0100, 1, 1, 0};
    vt[8]  = '{0, 4'b1111, 1, 4'b1000, 2, 1, 0};
    vt[9]  = '{0, 4'b1111, 1, 4'b0001, 3, 1, 0};
    vt[10] = '{0, 4'b1111, 1, 4'b0010, 0, 1, 0};
    vt[11] = '{0, 4'b1111, 1, 4'b0100, 1, 1, 0};
    vt[12] = '{0, 4'b1111, 1, 4'b1000, 2, 1, 0};
    vt[13] = '{0, 4'b1111, 0, 4'b0000, 3, 1, 0};
    vt[14] = '{0, 4'b1111, 0, 4'b0000, 3, 1, 0};
    vt[15] = '{0, 4'b1111, 0, 4'b0000, 3, 1, 0};
    vt[16] = '{0, 4'b0000, 1, 4'b0000, 3, 1, 0};
    vt[17] = '{0, 4'b0000, 1, 4'b0000, 3, 1, 0};
    vt[18] = '{0, 4'b0000, 1, 4'b0000, 3, 0, 0};
    vt[19] = '{0, 4'b0100, 1, 4'b0100, 3, 0, 0};
    vt[20] = '{0, 4'b1001, 1, 4'b1000, 2, 0, 0};
    vt[21] = '{0, 4'b1001, 1, 4'b0001, 3, 1, 0};
    vt[22] = '{0, 4'b1001, 1, 4'b1000, 0, 1, 0};
    vt[23] = '{0, 4'b0000, 1, 4'b0000, 3, 1, 0};
    vt[24] = '{0, 4'b0000, 1, 4'b0000, 3, 1, 0};
    vt[25] = '{0, 4'b0000, 1, 4'b0000, 3, 0, 0};
    vt[26] = '{0, 4'b0010, 1, 4'b0010, 3, 0, 0};
    vt[27] = '{0, 4'b0010, 1, 4'b0010, 1, 0, 0};
    vt[28] = '{0, 4'b0000, 1, 4'b0000, 1, 1, 0};
    vt[29] = '{1, 4'b1111, 0, 4'b0000, 1, 1, 0};
    vt[30] = '{0, 4'b1110, 1, 4'b0010, 0, 0, 1};
    vt[31] = '{0, 4'b0000, 1, 4'b0000, 1, 0, 0};
    vt[32] = '{0, 4'b0000, 1, 4'b0000, 1, 1, 0};
    vt[33] = '{0, 4'b0000, 1, 4'b0000, 1, 0, 0};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset A", {A3, A2, A1, A0, 16'd0}, 32'd0);
    chk("reset sel", 32'({SL1, SL0}), 32'd0);
    chk("reset out", {out_valid, out_data, out_lane}, 32'd0);
`ifdef MUX4_RR_SEQUENCER_CMP_EN
    chk("reset err", 32'(err), 32'd0);
`endif
    tick();
    rst = 1'b0;

    for (int i = 0; i < 34; i++) run_vec(i, vt[i]);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    // Single-lane data pass-through: lane 2 carries a known value onto A2 and back out.
    req_valid = 4'b0100;
    req_data  = 16'h0a00;
    out_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single A2", 32'(A2), 32'ha);
    tick();
    @(negedge clk);
    chk("single out", {out_valid, out_data, out_lane}, {25'd0, 1'b1, 4'ha, 2'd2});
    tick();

`ifdef MUX4_RR_SEQUENCER_CMP_EN
    // Stuck-at-1 on Z bit0 while lane 0 carries 1: captured ~Z bit0 is wrong.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    stuck     = 1'b1;
    req_valid = 4'b0001;
    req_data  = 16'h0001;
    @(negedge clk);
    chk("cmp err c0", 32'(err), 32'd0);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("cmp err c1", 32'(err), 32'd0);
    tick();
    @(negedge clk);
    chk("cmp err c2", 32'(err), 32'd1);
    stuck = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("cmp err sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("cmp err cleared", 32'(err), 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sequencer.md
Name: mux4_rr_sequencer

Overview:
- Upstream/downstream companion to the 4:1 inverting mux cell (Z = ~A[SL1:SL0]).
- Accepts up to four requesting lanes, arbitrates round-robin, and drives a registered select pair SL1/SL0 plus held lane data onto the mux inputs A0..A3.
- Captures the mux output Z one cycle later, restores polarity, and presents the result on a valid/ready output port.
- Serves as the stimulus and consumer harness for fault-injection runs on the mux cell array in the xsim std-cell models.

Parameters:
- WIDTH, 1: bits per lane; the mux is replicated bitwise, so Z is WIDTH bits.
- NLANE, 4: number of lanes; fixed at 4, with elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-lane request.
- req_data  in  4*WIDTH  lane data; lane i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  4  one-hot accept for the lane granted this cycle.
- A0..A3  out  WIDTH each  registered lane data to the mux inputs.
- SL0, SL1  out  1 each  registered select to the mux.
- Z  in  WIDTH  inverting mux output.
- out_valid  out  1  captured result valid.
- out_data  out  WIDTH  ~Z as captured, i.e. true lane data.
- out_lane  out  2  lane index of out_data.
- out_ready  in  1  downstream accept.
- err  out  1  sticky compare error; exists only with the optional feature.

Behaviour:
- Reset values: req_ready=0, A0..A3=0, SL0=0, SL1=0, out_valid=0, out_data=0, out_lane=0, err=0. The round-robin pointer resets to lane 0.
- Two-stage pipeline:
  - S0 issue: registers the select and all four A inputs.
  - S1 capture: registers ~Z.
- Request to out_valid latency is 2 cycles.
- Arbitration:
  - The granted lane is the first lane with req_valid=1, searching from ptr upward modulo 4.
  - On grant: req_ready[g]=1 (combinational, same cycle), ptr <= g+1 mod 4, {SL1,SL0} <= g, and A_g <= req_data[g].
  - Other A inputs hold their previous values.
  - Grant happens only when the issue slot is free.
- Issue slot: the slot is free when S1 is empty, or when out_ready=1 in the same cycle (i.e. S1 can advance).
- Stall: if out_valid=1 and out_ready=0:
  - req_ready=0.
  - SL0, SL1 and A0..A3 hold.
  - The captured value holds.
  - ptr holds.
- Bubble: with no request there is no grant. An internal issued flag is cleared and S1 does not load next cycle. Select and A inputs keep their values.
- Capture: when issued=1 and S1 can advance, out_data <= ~Z, out_lane <= {SL1,SL0}, out_valid <= 1.
  - If S1 advances with no issue, out_valid <= 0.
- Handshake: out_valid never drops without out_ready. out_data and out_lane are stable while out_valid=1 and out_ready=0.
- Throughput: with continuous requests and out_ready=1, one result per cycle.
- Wrap-around: ptr=3, grant 3 -> ptr=0.
- Multiple simultaneous requests: only one lane is granted per cycle; the others wait.
- Reset mid-operation: all pipeline contents are discarded, with no partial output, and ptr returns to 0.
- Z is X-propagated as-is; the block does not filter unknowns.

Optional Feature:
- Macro: MUX4_RR_SEQUENCER_CMP_EN.
- Defined:
  - Each capture compares ~Z with a shadow copy of the issued data.
  - A mismatch, including any X/Z bit (case-inequality), sets err=1. err is sticky until rst.
  - A one-cycle pulse is also raised internally and exposed as err.
  - The compare adds 1 register of WIDTH bits. Latency is unchanged.
- Undefined: no shadow register, and the err port is absent.

Decomposition:
- Shared package mux4_seq_pkg:
  - lane_idx_t (2-bit).
  - LANE_CNT=4.
  - function rr_pick(req, ptr), returning the granted index plus a found bit.
  - Polarity constant MUX_INVERTS=1.
- One sub-module is natural: rr_arb4. It is a combinational round-robin picker with the ptr register inside, an advance enable input, and grant/index outputs.
- Pipeline registers stay in the top module.

Test Plan:
- Single lane: req_valid=4'b0100, req_data lane2=1, mux model ties Z=~A[sel] -> at cycle 0 req_ready=4'b0100; at cycle 1 {SL1,SL0}=2'b10 and A2=1; at cycle 2 out_valid=1, out_data=1, out_lane=2.
- Round-robin fairness: all four req_valid held at 1 for 8 cycles with out_ready=1 -> grants in order 0,1,2,3,0,1,2,3 and out_lane sequence 0,1,2,3,0,1,2,3 starting at cycle 2.
- Backpressure: out_ready=0 for 3 cycles while 2 results are pending -> req_ready=0, SL/A held, out_data stable. On release, results drain in order with no loss or duplicate.
- Wrap and ptr: ptr=3, req_valid=4'b1001 -> lane 3 granted first, then lane 0, then ptr=1.
- Reset mid-flight: assert rst for 1 cycle while out_valid=1 -> next cycle all outputs are at reset values, and the next grant goes to the lowest requesting lane at or after 0.
- CMP_EN: force Z bit0 stuck-at-1 with issued data=1 (the correct Z is 0) -> err=1 two cycles after issue and remains 1 until rst.
